// File: rtl/i2c_angle_target.sv
// Purpose : I2C target at 7'h36 emulating the AS5600 angle/status registers from a fabric angle input.
// Latency : bus events act 3 clocks after the pin change; sda_oe follows one clock later (4 clocks).
// Backpressure: none; the initiator owns SCL and the target never stretches the clock.
//
// Ports:
//   clock, reset        system clock (>= 16x SCL) and synchronous active-high reset
//   scl_in, sda_in      asynchronous bus pins, oversampled on clock
//   sda_oe              1 = pull SDA low, 0 = release
//   angle[11:0]         angle to report; captured into a snapshot at the read address ACK
//   magnet_status[2:0]  {MD, ML, MH}, reported in STATUS[5:3]
//   reg_ptr[7:0]        current register pointer
//   busy                high from START through STOP
//   rd_strobe           one-cycle pulse when the initiator ACKs/NACKs a read byte
module i2c_angle_target (
    input  logic        clock,
    input  logic        reset,
    input  logic        scl_in,
    input  logic        sda_in,
    output logic        sda_oe,
    input  logic [11:0] angle,
    input  logic [2:0]  magnet_status,
    output logic [7:0]  reg_ptr,
    output logic        busy,
    output logic        rd_strobe
);

    localparam logic [6:0] TARGET_ADDR = 7'h36;

    typedef enum logic [3:0] {
        S_IDLE,
        S_ADDR,
        S_ADDR_ACK,
        S_WR_PTR,
        S_WR_DATA,
        S_WR_ACK,
        S_RD_DATA,
        S_RD_ACK,
        S_WAIT_STOP
    } state_t;

    state_t      state;

    // Synchronizer (two flops) plus one history flop per pin.
    logic        scl_s1, scl_s2, scl_d;
    logic        sda_s1, sda_s2, sda_d;

    logic [3:0]  bit_cnt;
    logic [7:0]  shift;
    logic [7:0]  tx;
    logic [11:0] snap;
    logic        ack_drv;   // set while the ACK bit itself is being driven
    logic        rw;
    logic        oe_next;   // bit decided at the SCL fall; presented on sda_oe one clock later

    logic        scl_rise, scl_fall, start_det, stop_det;
    logic [7:0]  sh_in;
    logic [7:0]  rd_byte;

    assign scl_rise  =  scl_s2 & ~scl_d;
    assign scl_fall  = ~scl_s2 &  scl_d;
    assign start_det =  scl_s2 &  scl_d &  sda_d & ~sda_s2;
    assign stop_det  =  scl_s2 &  scl_d & ~sda_d &  sda_s2;
    assign sh_in     = {shift[6:0], sda_s2};

    // Register map seen by the reader; angle bytes come from the snapshot so
    // a multi-byte read is coherent. 0x0E/0x0F mirror 0x0C/0x0D.
    always_comb begin
        rd_byte = 8'h00;
        case (reg_ptr)
            8'h0B:        rd_byte = {2'b00, magnet_status, 3'b000};
            8'h0C, 8'h0E: rd_byte = {4'h0, snap[11:8]};
            8'h0D, 8'h0F: rd_byte = snap[7:0];
            default:      rd_byte = 8'h00;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            scl_s1    <= 1'b1;
            scl_s2    <= 1'b1;
            scl_d     <= 1'b1;
            sda_s1    <= 1'b1;
            sda_s2    <= 1'b1;
            sda_d     <= 1'b1;
            state     <= S_IDLE;
            bit_cnt   <= 4'd0;
            shift     <= 8'h00;
            tx        <= 8'h00;
            snap      <= 12'h000;
            ack_drv   <= 1'b0;
            rw        <= 1'b0;
            oe_next   <= 1'b0;
            sda_oe    <= 1'b0;
            reg_ptr   <= 8'h00;
            busy      <= 1'b0;
            rd_strobe <= 1'b0;
        end else begin
            scl_s1    <= scl_in;
            scl_s2    <= scl_s1;
            scl_d     <= scl_s2;
            sda_s1    <= sda_in;
            sda_s2    <= sda_s1;
            sda_d     <= sda_s2;
            sda_oe    <= oe_next;
            rd_strobe <= 1'b0;

            // START/STOP win over any data activity in the same cycle.
            if (start_det) begin
                state   <= S_ADDR;
                bit_cnt <= 4'd0;
                ack_drv <= 1'b0;
                oe_next <= 1'b0;
                busy    <= 1'b1;
            end else if (stop_det) begin
                state   <= S_IDLE;
                ack_drv <= 1'b0;
                oe_next <= 1'b0;
                busy    <= 1'b0;
            end else begin
                case (state)
                    S_ADDR: begin
                        if (scl_rise) begin
                            shift   <= sh_in;
                            bit_cnt <= bit_cnt + 4'd1;
                            if (bit_cnt == 4'd7) begin
                                bit_cnt <= 4'd0;
                                ack_drv <= 1'b0;
                                if (sh_in[7:1] == TARGET_ADDR) begin
                                    rw    <= sh_in[0];
                                    state <= S_ADDR_ACK;
                                end else begin
                                    state <= S_WAIT_STOP;
                                end
                            end
                        end
                    end

                    S_ADDR_ACK: begin
                        if (scl_fall) begin
                            if (!ack_drv) begin
                                ack_drv <= 1'b1;
                                oe_next <= 1'b1;
                                if (rw) snap <= angle;
                            end else begin
                                ack_drv <= 1'b0;
                                bit_cnt <= 4'd0;
                                if (rw) begin
                                    tx      <= rd_byte;
                                    oe_next <= ~rd_byte[7];
                                    state   <= S_RD_DATA;
                                end else begin
                                    oe_next <= 1'b0;
                                    state   <= S_WR_PTR;
                                end
                            end
                        end
                    end

                    S_WR_PTR, S_WR_DATA: begin
                        if (scl_rise) begin
                            shift   <= sh_in;
                            bit_cnt <= bit_cnt + 4'd1;
                            if (bit_cnt == 4'd7) begin
                                bit_cnt <= 4'd0;
                                ack_drv <= 1'b0;
                                state   <= S_WR_ACK;
                                // First byte is the pointer, later bytes only advance it.
                                reg_ptr <= (state == S_WR_PTR) ? sh_in : reg_ptr + 8'd1;
                            end
                        end
                    end

                    S_WR_ACK: begin
                        if (scl_fall) begin
                            if (!ack_drv) begin
                                ack_drv <= 1'b1;
                                oe_next <= 1'b1;
                            end else begin
                                ack_drv <= 1'b0;
                                oe_next <= 1'b0;
                                state   <= S_WR_DATA;
                            end
                        end
                    end

                    S_RD_DATA: begin
                        if (scl_rise) begin
                            bit_cnt <= bit_cnt + 4'd1;
                        end else if (scl_fall) begin
                            if (bit_cnt == 4'd8) begin
                                oe_next <= 1'b0;
                                bit_cnt <= 4'd0;
                                state   <= S_RD_ACK;
                            end else begin
                                oe_next <= ~tx[6];
                                tx      <= {tx[6:0], 1'b0};
                            end
                        end
                    end

                    S_RD_ACK: begin
                        if (scl_rise) begin
                            rd_strobe <= 1'b1;
                            reg_ptr   <= reg_ptr + 8'd1;
                            if (sda_s2) state <= S_WAIT_STOP;
                        end else if (scl_fall) begin
                            // Initiator ACKed: next byte uses the already advanced pointer.
                            tx      <= rd_byte;
                            oe_next <= ~rd_byte[7];
                            bit_cnt <= 4'd0;
                            state   <= S_RD_DATA;
                        end
                    end

                    S_WAIT_STOP: oe_next <= 1'b0;
                    S_IDLE:      oe_next <= 1'b0;
                    default:     state   <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_angle_target.sv
// Purpose : self-checking bench for i2c_angle_target driving a bit-level I2C initiator.
// Latency : SCL half period of 20 system clocks; all stimulus changes just after a falling clock edge.
// Backpressure: n/a (bench owns SCL).
module tb_i2c_angle_target;

    localparam int Q = 10;
    localparam int H = 20;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        scl   = 1'b1;
    logic        sda_m = 1'b1;
    logic        sda_line;
    logic        sda_oe;
    logic [11:0] angle = 12'h000;
    logic [2:0]  ms    = 3'b000;
    logic [7:0]  reg_ptr;
    logic        busy;
    logic        rd_strobe;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          strobe_cnt = 0;
    int          oe_cnt     = 0;
    logic [7:0]  mdl_ptr = 8'h00;

    always #5 clock = ~clock;

    // Open-drain bus: either side can pull low.
    assign sda_line = sda_m & ~sda_oe;

    i2c_angle_target dut (
        .clock(clock), .reset(reset), .scl_in(scl), .sda_in(sda_line),
        .sda_oe(sda_oe), .angle(angle), .magnet_status(ms),
        .reg_ptr(reg_ptr), .busy(busy), .rd_strobe(rd_strobe)
    );

    always @(posedge clock) begin
        if (rd_strobe) strobe_cnt++;
        if (sda_oe) oe_cnt++;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    function automatic logic [7:0] model_byte(input logic [7:0] p, input logic [11:0] snp, input logic [2:0] st);
        logic [7:0] m [0:255];
        for (int i = 0; i < 256; i++) m[i] = 8'h00;
        m[8'h0B] = {2'b00, st, 3'b000};
        m[8'h0C] = {4'h0, snp[11:8]};
        m[8'h0D] = snp[7:0];
        m[8'h0E] = m[8'h0C];
        m[8'h0F] = m[8'h0D];
        return m[p];
    endfunction

    // ---------------- bus primitives ----------------
    task automatic wait_clk(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic i2c_start;
        sda_m = 1'b1; wait_clk(Q);
        scl = 1'b1;   wait_clk(H);
        sda_m = 1'b0; wait_clk(H);
        scl = 1'b0;   wait_clk(Q);
    endtask

    task automatic i2c_stop;
        sda_m = 1'b0; wait_clk(Q);
        scl = 1'b1;   wait_clk(H);
        sda_m = 1'b1; wait_clk(H);
    endtask

    task automatic write_bit(input logic b);
        sda_m = b;  wait_clk(Q);
        scl = 1'b1; wait_clk(H);
        scl = 1'b0; wait_clk(Q);
    endtask

    task automatic read_bit(output logic b);
        sda_m = 1'b1; wait_clk(Q);
        scl = 1'b1;   wait_clk(H / 2);
        b = sda_line; wait_clk(H / 2);
        scl = 1'b0;   wait_clk(Q);
    endtask

    task automatic wr_byte(input logic [7:0] b, output logic ack);
        for (int i = 7; i >= 0; i--) write_bit(b[i]);
        read_bit(ack);
    endtask

    task automatic rd_byte(input logic nack, output logic [7:0] b);
        logic v;
        for (int i = 7; i >= 0; i--) begin
            read_bit(v);
            b[i] = v;
        end
        write_bit(nack);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset;
        reset = 1'b1; wait_clk(5);
        reset = 1'b0; wait_clk(3);
        n_checks++; if (sda_oe !== 1'b0) begin n_fail++; $display("FAIL reset_sda_oe: got %b want 0", sda_oe); end
        n_checks++; if (reg_ptr !== 8'h00) begin n_fail++; $display("FAIL reset_reg_ptr: got %h want 00", reg_ptr); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_checks++; if (rd_strobe !== 1'b0) begin n_fail++; $display("FAIL reset_rd_strobe: got %b want 0", rd_strobe); end
        mdl_ptr = 8'h00;
    endtask

    task automatic test_ack_latency;
        logic [7:0] a8 = 8'h6C;
        logic a;
        i2c_start;
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL busy_after_start: got %b want 1", busy); end
        for (int i = 7; i >= 1; i--) write_bit(a8[i]);
        sda_m = a8[0]; wait_clk(Q);
        scl = 1'b1;    wait_clk(H);
        scl = 1'b0;    wait_clk(3);
        n_checks++; if (sda_oe !== 1'b0) begin n_fail++; $display("FAIL ack_latency_early: got %b want 0 at 3 clocks", sda_oe); end
        wait_clk(1);
        n_checks++; if (sda_oe !== 1'b1) begin n_fail++; $display("FAIL ack_latency: got %b want 1 at 4 clocks", sda_oe); end
        wait_clk(Q - 4);
        read_bit(a);
        n_checks++; if (a !== 1'b0) begin n_fail++; $display("FAIL ack_latency_ack: got %b want 0", a); end
        i2c_stop;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL busy_after_stop: got %b want 0", busy); end
    endtask

    task automatic test_ptr_read;
        logic        a;
        logic [7:0]  b, p, exp;
        logic [11:0] snp;
        int          n, s0;
        for (int it = 0; it < 5; it++) begin
            angle = (it == 0) ? 12'hABC : 12'($urandom);
            p     = (it == 0) ? 8'h0C : 8'($urandom_range(8'h0A, 8'h10));
            n     = (it == 0) ? 2 : $urandom_range(1, 3);
            s0    = strobe_cnt;
            i2c_start;
            wr_byte(8'h6C, a);
            n_checks++; if (a !== 1'b0) begin n_fail++; $display("FAIL ptr_read_addr_ack it%0d: got %b want 0", it, a); end
            wr_byte(p, a);
            n_checks++; if (a !== 1'b0) begin n_fail++; $display("FAIL ptr_read_ptr_ack it%0d: got %b want 0", it, a); end
            mdl_ptr = p;
            i2c_start;
            wr_byte(8'h6D, a);
            n_checks++; if (a !== 1'b0) begin n_fail++; $display("FAIL ptr_read_raddr_ack it%0d: got %b want 0", it, a); end
            snp = angle;
            for (int k = 0; k < n; k++) begin
                rd_byte(k == n - 1, b);
                exp = model_byte(mdl_ptr, snp, ms);
                mdl_ptr = mdl_ptr + 8'd1;
                n_checks++; if (b !== exp) begin n_fail++; $display("FAIL ptr_read_data it%0d byte%0d: got %h want %h", it, k, b, exp); end
            end
            i2c_stop;
            n_checks++; if (strobe_cnt - s0 !== n) begin n_fail++; $display("FAIL ptr_read_strobes it%0d: got %0d want %0d", it, strobe_cnt - s0, n); end
            n_checks++; if (reg_ptr !== mdl_ptr) begin n_fail++; $display("FAIL ptr_read_reg_ptr it%0d: got %h want %h", it, reg_ptr, mdl_ptr); end
        end
    endtask

    task automatic test_no_match;
        logic a;
        int   o0 = oe_cnt;
        i2c_start;
        wr_byte(8'h6E, a);
        n_checks++; if (a !== 1'b1) begin n_fail++; $display("FAIL nomatch_addr_nack: got %b want 1", a); end
        wr_byte(8'h55, a);
        n_checks++; if (a !== 1'b1) begin n_fail++; $display("FAIL nomatch_data_nack: got %b want 1", a); end
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL nomatch_busy: got %b want 1", busy); end
        i2c_stop;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL nomatch_busy_end: got %b want 0", busy); end
        n_checks++; if (oe_cnt - o0 !== 0) begin n_fail++; $display("FAIL nomatch_sda_oe: got %0d driven cycles want 0", oe_cnt - o0); end
        n_checks++; if (reg_ptr !== mdl_ptr) begin n_fail++; $display("FAIL nomatch_reg_ptr: got %h want %h", reg_ptr, mdl_ptr); end
    endtask

    task automatic test_snapshot;
        logic        a;
        logic [7:0]  b1, b2;
        logic [11:0] snp;
        for (int pass = 0; pass < 2; pass++) begin
            angle = (pass == 0) ? 12'hABC : 12'h123;
            i2c_start; wr_byte(8'h6C, a); wr_byte(8'h0C, a);
            i2c_start; wr_byte(8'h6D, a);
            snp = angle;
            rd_byte(1'b0, b1);
            angle = 12'($urandom) | 12'h800;
            rd_byte(1'b1, b2);
            i2c_stop;
            if (pass == 0) angle = 12'h123;
            n_checks++; if (b1 !== model_byte(8'h0C, snp, ms)) begin n_fail++; $display("FAIL snapshot_hi p%0d: got %h want %h", pass, b1, model_byte(8'h0C, snp, ms)); end
            n_checks++; if (b2 !== model_byte(8'h0D, snp, ms)) begin n_fail++; $display("FAIL snapshot_lo p%0d: got %h want %h", pass, b2, model_byte(8'h0D, snp, ms)); end
        end
        mdl_ptr = 8'h0E;
    endtask

    task automatic test_status;
        logic       a;
        logic [7:0] b;
        logic [7:0] ptrs [0:1];
        ptrs[0] = 8'h0B; ptrs[1] = 8'h10;
        ms = 3'b100;
        for (int k = 0; k < 2; k++) begin
            i2c_start; wr_byte(8'h6C, a); wr_byte(ptrs[k], a);
            i2c_start; wr_byte(8'h6D, a);
            rd_byte(1'b1, b);
            i2c_stop;
            n_checks++; if (b !== model_byte(ptrs[k], angle, ms)) begin n_fail++; $display("FAIL status_read %h: got %h want %h", ptrs[k], b, model_byte(ptrs[k], angle, ms)); end
        end
        mdl_ptr = 8'h11;
        ms = 3'($urandom);
    endtask

    task automatic test_wrap;
        logic       a, v;
        logic [7:0] b1, b2;
        int         o0;
        i2c_start; wr_byte(8'h6C, a); wr_byte(8'hFF, a);
        i2c_start; wr_byte(8'h6D, a);
        rd_byte(1'b0, b1);
        for (int i = 7; i >= 0; i--) begin
            read_bit(v);
            b2[i] = v;
        end
        o0 = oe_cnt;
        write_bit(1'b1);
        i2c_stop;
        n_checks++; if (b1 !== 8'h00) begin n_fail++; $display("FAIL wrap_byte1: got %h want 00", b1); end
        n_checks++; if (b2 !== 8'h00) begin n_fail++; $display("FAIL wrap_byte2: got %h want 00", b2); end
        n_checks++; if (reg_ptr !== 8'h01) begin n_fail++; $display("FAIL wrap_reg_ptr: got %h want 01", reg_ptr); end
        n_checks++; if (oe_cnt - o0 !== 0) begin n_fail++; $display("FAIL wrap_nack_release: got %0d driven cycles want 0", oe_cnt - o0); end
        mdl_ptr = 8'h01;
    endtask

    task automatic test_reset_mid;
        logic        a;
        logic [7:0]  b1, b2;
        logic [11:0] snp;
        angle = 12'h700;   // low byte 0x00: every data bit is driven low
        i2c_start; wr_byte(8'h6C, a); wr_byte(8'h0D, a); i2c_stop;
        i2c_start; wr_byte(8'h6D, a);
        sda_m = 1'b1; wait_clk(Q);
        scl = 1'b1;   wait_clk(H / 2);
        n_checks++; if (sda_oe !== 1'b1) begin n_fail++; $display("FAIL resetmid_driving: got %b want 1", sda_oe); end
        reset = 1'b1; wait_clk(1);
        n_checks++; if (sda_oe !== 1'b0) begin n_fail++; $display("FAIL resetmid_release: got %b want 0", sda_oe); end
        wait_clk(2);
        reset = 1'b0;
        mdl_ptr = 8'h00;
        wait_clk(2);
        n_checks++; if (reg_ptr !== mdl_ptr || busy !== 1'b0) begin n_fail++; $display("FAIL resetmid_state: got ptr %h busy %b want 00 0", reg_ptr, busy); end
        scl = 1'b0; wait_clk(Q);
        angle = 12'($urandom);
        i2c_start; wr_byte(8'h6C, a); wr_byte(8'h0C, a);
        i2c_start; wr_byte(8'h6D, a);
        n_checks++; if (a !== 1'b0) begin n_fail++; $display("FAIL resetmid_ack: got %b want 0", a); end
        snp = angle;
        rd_byte(1'b0, b1);
        rd_byte(1'b1, b2);
        i2c_stop;
        n_checks++; if (b1 !== model_byte(8'h0C, snp, ms) || b2 !== model_byte(8'h0D, snp, ms)) begin
            n_fail++; $display("FAIL resetmid_read: got %h %h want %h %h", b1, b2, model_byte(8'h0C, snp, ms), model_byte(8'h0D, snp, ms));
        end
        n_checks++; if (reg_ptr !== 8'h0E) begin n_fail++; $display("FAIL resetmid_reg_ptr: got %h want 0E", reg_ptr); end
    endtask

    initial begin
        test_reset;
        test_ack_latency;
        test_ptr_read;
        test_no_match;
        test_snapshot;
        test_status;
        test_wrap;
        test_reset_mid;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/i2c_angle_target.md
# i2c_angle_target

Synthesizable I2C target (slave) that emulates the AS5600 magnetic encoder's angle and status registers at 7-bit address 0x36. It serves the same register reads that the subsystem's I2C angle reader issues, so a PWM control loop can be closed in hardware-in-the-loop or on-FPGA self-test without a physical sensor. The angle it reports comes from a fabric input. The block oversamples SCL/SDA on the system clock and drives SDA open-drain through an output-enable.

## Interface
- No parameters; target address fixed at 7'h36.
- clock  in  1  system clock; must be >= 16x SCL frequency
- reset  in  1  synchronous, active-high reset
- scl_in  in  1  I2C clock from bus (asynchronous)
- sda_in  in  1  I2C data from bus (asynchronous)
- sda_oe  out  1  1 = pull SDA low; 0 = release (external pull-up)
- angle  in  12  angle value to report, 0..4095
- magnet_status  in  3  {MD, ML, MH} reported in STATUS[5:3]
- reg_ptr  out  8  current register pointer
- busy  out  1  high from START through STOP (addressed or not)
- rd_strobe  out  1  one-cycle pulse when a read byte is ACKed or NACKed by the initiator

## Operation
- Input path: scl_in/sda_in → 2-flop synchronizer → 1 history register. START = SDA fall while SCL high. STOP = SDA rise while SCL high. Bits are sampled on the SCL rising edge. SDA changes on the SCL falling edge.
- States:
  - IDLE → ADDR on START.
  - ADDR: shift 8 bits, MSB first.
    - On match (7'h36): → ADDR_ACK.
    - Else → WAIT_STOP.
  - ADDR_ACK: drive ACK for one SCL period.
    - R/W=0 → WR_PTR.
    - R/W=1 → RD_DATA, and capture snapshot = angle at the SCL fall that starts ACK.
  - WR_PTR: 8 bits → reg_ptr, then PTR_ACK → WR_DATA.
  - WR_DATA: bytes ACKed and discarded; reg_ptr += 1 per byte.
  - RD_DATA: shift out the register byte MSB first, then RD_ACK samples the initiator's bit.
    - 0 (ACK) → RD_DATA with reg_ptr += 1.
    - 1 (NACK) → WAIT_STOP; reg_ptr still += 1.
  - WAIT_STOP: sda_oe = 0; ignore the bus until STOP or START.
- START in any state (repeated start) → ADDR; bit counter is cleared and reg_ptr is kept. STOP in any state → IDLE.
- Register map, read from the snapshot:
  - 0x0B = {2'b00, magnet_status, 3'b000}
  - 0x0C = {4'h0, snap[11:8]}
  - 0x0D = snap[7:0]
  - 0x0E = 0x0C
  - 0x0F = 0x0D
  - all other addresses = 0x00
- reg_ptr wraps 0xFF → 0x00. The byte to transmit is loaded at the SCL fall ending the previous ACK.
- sda_oe is asserted only for a data bit of 0 or for an ACK; never while SCL is high except to hold a bit.

## Timing
- Reset values: sda_oe = 0, reg_ptr = 0x00, busy = 0, rd_strobe = 0, state IDLE, snapshot = 0.
- Event latency: every bus event (edge, START, STOP) acts 3 clock cycles after the pin change (2 sync + 1 detect). sda_oe updates on the cycle after the detected SCL fall, i.e. 4 cycles after the pin change.
- ACK: sda_oe = 1 from the SCL fall after bit 8 until the following SCL fall.
- rd_strobe: asserted on the cycle the initiator's ACK/NACK bit is sampled.
- busy: rises on the cycle START is detected; falls on the cycle STOP is detected.
- Simultaneous events: START/STOP detection has priority over data sampling in the same cycle.
- Reset mid-transfer: sda_oe is released in the same cycle reset is sampled; the next transaction requires a fresh START.
- Snapshot is held for the whole read transaction, so hi/lo bytes stay coherent even if angle changes.

## Test plan
- Write ptr 0x0C, repeated START, read 2 bytes with angle = 12'hABC → bytes 0x0A, 0x BC; ACK on address and pointer; rd_strobe pulses twice; reg_ptr = 0x0E after.
- Address 0x37 write → no ACK (sda_oe stays 0 throughout); busy high until STOP; reg_ptr unchanged.
- Read at 0x0C, angle changes 0xABC → 0x123 between byte 1 and byte 2 → reads 0x0A, 0xBC; next transaction reads 0x01, 0x23.
- magnet_status = 3'b100, read 0x0B → 0x20; read 0x10 → 0x00.
- Pointer set to 0xFF, read 2 bytes → 0x00, 0x00; reg_ptr = 0x01; NACK on byte 2 → sda_oe stays 0 until STOP.
- Assert reset while the target drives a 0 bit → sda_oe = 0 the next cycle; a subsequent normal read succeeds.
